// File: rtl/branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue
//
// Buffers branches and jump-registers whose operands may still be pending
// ROB references. Entries sit in an in-order circular queue, snoop the CDB
// for their pending operands, and the head entry is evaluated once it has
// everything it needs. One resolution per cycle leaves through a registered
// valid/ready output, in program order, carrying the actual direction, a
// mispredict flag and the corrected next fetch PC.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   flush               empties the queue and the output register
//   alloc_*             allocation request from ID (alloc_ready = not full)
//   cdb_en/tag/data     common data bus broadcast
//   res_valid/res_ready resolution handshake
//   res_rob_tag, res_taken, res_mispredict, res_next_pc  resolution payload
//   count               number of occupied entries
// ---------------------------------------------------------------------------
module branch_resolve_queue #(
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         alloc_en,
  output logic                         alloc_ready,
  input  logic [2:0]                   alloc_cond,
  input  logic [ADDR_WIDTH-1:0]        alloc_pc,
  input  logic [ADDR_WIDTH-1:0]        alloc_target,
  input  logic                         alloc_pred_taken,
  input  logic [TAG_WIDTH-1:0]         alloc_rob_tag,
  input  logic                         alloc_is_ref_1,
  input  logic                         alloc_is_ref_2,
  input  logic [DATA_WIDTH-1:0]        alloc_data_1,
  input  logic [DATA_WIDTH-1:0]        alloc_data_2,
  input  logic                         cdb_en,
  input  logic [TAG_WIDTH-1:0]         cdb_tag,
  input  logic [DATA_WIDTH-1:0]        cdb_data,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [TAG_WIDTH-1:0]         res_rob_tag,
  output logic                         res_taken,
  output logic                         res_mispredict,
  output logic [ADDR_WIDTH-1:0]        res_next_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    COND_EQ  = 3'd0,
    COND_NE  = 3'd1,
    COND_GTZ = 3'd2,
    COND_LEZ = 3'd3,
    COND_LTZ = 3'd4,
    COND_GEZ = 3'd5,
    COND_JR  = 3'd6,
    COND_RSV = 3'd7
  } cond_e;

  typedef struct packed {
    cond_e                  cond;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  target;
    logic                   pred;
    logic [TAG_WIDTH-1:0]   rob_tag;
    logic                   pend_1;
    logic                   pend_2;
    logic [DATA_WIDTH-1:0]  op_1;   // value, or waited-on tag while pending
    logic [DATA_WIDTH-1:0]  op_2;
  } entry_t;

  // Control state
  logic [DEPTH-1:0]       r_valid;
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;

  // Entry payload
  entry_t                 r_mem [DEPTH];

  // Output register
  logic                   r_res_valid;
  logic [TAG_WIDTH-1:0]   r_res_rob_tag;
  logic                   r_res_taken;
  logic                   r_res_mispredict;
  logic [ADDR_WIDTH-1:0]  r_res_next_pc;

  // Combinational
  logic                   w_alloc;
  logic                   w_pop;
  logic                   w_head_ready;
  entry_t                 w_head;
  entry_t                 w_new;
  logic                   w_need_1;
  logic                   w_need_2;
  logic                   w_hit_1;
  logic                   w_hit_2;
  logic                   w_taken;
  logic                   w_mispredict;
  logic [ADDR_WIDTH-1:0]  w_next_pc;
  logic [ADDR_WIDTH-1:0]  w_op1_addr;
  logic                   w_a_neg;
  logic                   w_a_zero;

  // Readiness is a function of registered count only, so a same-cycle pop
  // never makes room for an allocate into a full queue.
  assign alloc_ready = (r_count != CNT_W'(DEPTH));
  assign w_alloc     = alloc_en && alloc_ready;

  assign w_head       = r_mem[r_head];
  // Unneeded operands are stored as ready, so the pending flags alone decide.
  assign w_head_ready = r_valid[r_head] && !w_head.pend_1 && !w_head.pend_2;
  assign w_pop        = w_head_ready && (!r_res_valid || res_ready);

  // Build the entry to be written, including the same-cycle CDB bypass.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_new          = '0;
    w_need_1       = (alloc_cond != COND_RSV);
    w_need_2       = (alloc_cond == COND_EQ) || (alloc_cond == COND_NE);
    w_hit_1        = cdb_en && (alloc_data_1[TAG_WIDTH-1:0] == cdb_tag);
    w_hit_2        = cdb_en && (alloc_data_2[TAG_WIDTH-1:0] == cdb_tag);
    w_new.cond     = cond_e'(alloc_cond);
    w_new.pc       = alloc_pc;
    w_new.target   = alloc_target;
    w_new.pred     = alloc_pred_taken;
    w_new.rob_tag  = alloc_rob_tag;
    w_new.pend_1   = w_need_1 && alloc_is_ref_1 && !w_hit_1;
    w_new.pend_2   = w_need_2 && alloc_is_ref_2 && !w_hit_2;
    w_new.op_1     = (alloc_is_ref_1 && w_hit_1) ? cdb_data : alloc_data_1;
    w_new.op_2     = (alloc_is_ref_2 && w_hit_2) ? cdb_data : alloc_data_2;
  end

  // Evaluate the head entry.
  always_comb begin
    w_a_neg      = w_head.op_1[DATA_WIDTH-1];
    w_a_zero     = (w_head.op_1 == '0);
    w_op1_addr   = ADDR_WIDTH'(w_head.op_1);
    w_taken      = 1'b0;
    case (w_head.cond)
      COND_EQ:  w_taken = (w_head.op_1 == w_head.op_2);
      COND_NE:  w_taken = (w_head.op_1 != w_head.op_2);
      COND_GTZ: w_taken = !w_a_neg && !w_a_zero;
      COND_LEZ: w_taken = w_a_neg || w_a_zero;
      COND_LTZ: w_taken = w_a_neg;
      COND_GEZ: w_taken = !w_a_neg;
      COND_JR:  w_taken = 1'b1;
      default:  w_taken = 1'b0;
    endcase
    if (w_head.cond == COND_JR) begin
      w_next_pc    = w_op1_addr;
      w_mispredict = !w_head.pred || (w_op1_addr != w_head.target);
    end else begin
      // Fall-through skips the delay slot; wraps modulo 2^ADDR_WIDTH.
      w_next_pc    = w_taken ? w_head.target : (w_head.pc + ADDR_WIDTH'(8));
      w_mispredict = (w_taken != w_head.pred);
    end
  end

  // Control state and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid          <= '0;
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_res_valid      <= 1'b0;
      r_res_rob_tag    <= '0;
      r_res_taken      <= 1'b0;
      r_res_mispredict <= 1'b0;
      r_res_next_pc    <= '0;
    end else if (flush) begin
      r_valid          <= '0;
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_res_valid      <= 1'b0;
      r_res_rob_tag    <= '0;
      r_res_taken      <= 1'b0;
      r_res_mispredict <= 1'b0;
      r_res_next_pc    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);

      if (w_pop) begin
        r_res_valid      <= 1'b1;
        r_res_rob_tag    <= w_head.rob_tag;
        r_res_taken      <= w_taken;
        r_res_mispredict <= w_mispredict;
        r_res_next_pc    <= w_next_pc;
      end else if (res_ready) begin
        r_res_valid      <= 1'b0;
      end
    end
  end

  // NOTE: entry payload has no reset; r_valid gates every use of it, and
  // leaving the storage unreset lets it map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && cdb_en) begin
          if (r_mem[i].pend_1 && (r_mem[i].op_1[TAG_WIDTH-1:0] == cdb_tag)) begin
            r_mem[i].op_1   <= cdb_data;
            r_mem[i].pend_1 <= 1'b0;
          end
          if (r_mem[i].pend_2 && (r_mem[i].op_2[TAG_WIDTH-1:0] == cdb_tag)) begin
            r_mem[i].op_2   <= cdb_data;
            r_mem[i].pend_2 <= 1'b0;
          end
        end
      end
      // The tail slot is never valid while allocatable, so this cannot
      // collide with the snoop writes above.
      if (w_alloc) begin
        r_mem[r_tail] <= w_new;
      end
    end
  end

  assign res_valid      = r_res_valid;
  assign res_rob_tag    = r_res_rob_tag;
  assign res_taken      = r_res_taken;
  assign res_mispredict = r_res_mispredict;
  assign res_next_pc    = r_res_next_pc;
  assign count          = r_count;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// Directed testbench for branch_resolve_queue (DEPTH=4, 32-bit PC/data).
// Inputs change 1 time unit after the rising edge and outputs are sampled
// at the same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alloc_en;
  logic        alloc_ready;
  logic [2:0]  alloc_cond;
  logic [31:0] alloc_pc;
  logic [31:0] alloc_target;
  logic        alloc_pred_taken;
  logic [3:0]  alloc_rob_tag;
  logic        alloc_is_ref_1;
  logic        alloc_is_ref_2;
  logic [31:0] alloc_data_1;
  logic [31:0] alloc_data_2;
  logic        cdb_en;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_rob_tag;
  logic        res_taken;
  logic        res_mispredict;
  logic [31:0] res_next_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  branch_resolve_queue #(
    .DEPTH(4), .TAG_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_en(alloc_en), .alloc_ready(alloc_ready), .alloc_cond(alloc_cond),
    .alloc_pc(alloc_pc), .alloc_target(alloc_target),
    .alloc_pred_taken(alloc_pred_taken), .alloc_rob_tag(alloc_rob_tag),
    .alloc_is_ref_1(alloc_is_ref_1), .alloc_is_ref_2(alloc_is_ref_2),
    .alloc_data_1(alloc_data_1), .alloc_data_2(alloc_data_2),
    .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_rob_tag(res_rob_tag),
    .res_taken(res_taken), .res_mispredict(res_mispredict),
    .res_next_pc(res_next_pc), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic [2:0] cond, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic pred,
                           input logic [3:0] rob, input logic ref1,
                           input logic [31:0] d1, input logic ref2,
                           input logic [31:0] d2);
    alloc_en         = 1'b1;
    alloc_cond       = cond;
    alloc_pc         = pc;
    alloc_target     = tgt;
    alloc_pred_taken = pred;
    alloc_rob_tag    = rob;
    alloc_is_ref_1   = ref1;
    alloc_data_1     = d1;
    alloc_is_ref_2   = ref2;
    alloc_data_2     = d2;
  endtask

  task automatic clear_inputs();
    alloc_en = 1'b0;
    cdb_en   = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; alloc_en = 1'b0; alloc_cond = '0;
    alloc_pc = '0; alloc_target = '0; alloc_pred_taken = 1'b0;
    alloc_rob_tag = '0; alloc_is_ref_1 = 1'b0; alloc_is_ref_2 = 1'b0;
    alloc_data_1 = '0; alloc_data_2 = '0; cdb_en = 1'b0; cdb_tag = '0;
    cdb_data = '0; res_ready = 1'b1;
    #3;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%0h exp=0", res_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got=%0h exp=1", alloc_ready); end
    checks++; if ({res_rob_tag, res_taken, res_mispredict, res_next_pc} !== '0) begin
      errors++; $display("FAIL reset_res_fields got tag=%0h t=%0h m=%0h pc=%0h exp all 0", res_rob_tag, res_taken, res_mispredict, res_next_pc);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ready_beq();
    set_alloc(3'd0, 32'h100, 32'h200, 1'b0, 4'd1, 1'b0, 32'd5, 1'b0, 32'd5);
    tick();
    clear_inputs();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL beq_count_after_alloc got=%0d exp=1", count); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL beq_not_yet_valid got=%0h exp=0", res_valid); end
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL beq_valid got=%0h exp=1", res_valid); end
    checks++; if (res_taken !== 1'b1) begin errors++; $display("FAIL beq_taken got=%0h exp=1", res_taken); end
    checks++; if (res_mispredict !== 1'b1) begin errors++; $display("FAIL beq_mispredict got=%0h exp=1", res_mispredict); end
    checks++; if (res_next_pc !== 32'h200) begin errors++; $display("FAIL beq_next_pc got=%0h exp=200", res_next_pc); end
    checks++; if (res_rob_tag !== 4'd1) begin errors++; $display("FAIL beq_rob_tag got=%0h exp=1", res_rob_tag); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL beq_count_after_pop got=%0d exp=0", count); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL beq_consumed got=%0h exp=0", res_valid); end
  endtask

  task automatic test_pending_bne();
    set_alloc(3'd1, 32'h120, 32'h300, 1'b0, 4'd2, 1'b1, 32'd3, 1'b0, 32'd7);
    tick();
    clear_inputs();
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bne_waits got=%0h exp=0", res_valid); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL bne_count got=%0d exp=1", count); end
    cdb_en = 1'b1; cdb_tag = 4'd3; cdb_data = 32'd7;
    tick();
    clear_inputs();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bne_capture_edge got=%0h exp=0", res_valid); end
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bne_valid got=%0h exp=1", res_valid); end
    checks++; if (res_taken !== 1'b0) begin errors++; $display("FAIL bne_taken got=%0h exp=0", res_taken); end
    checks++; if (res_mispredict !== 1'b0) begin errors++; $display("FAIL bne_mispredict got=%0h exp=0", res_mispredict); end
    checks++; if (res_next_pc !== 32'h128) begin errors++; $display("FAIL bne_next_pc got=%0h exp=128", res_next_pc); end
    tick();
  endtask

  task automatic test_bypass();
    set_alloc(3'd4, 32'h140, 32'h500, 1'b1, 4'd3, 1'b1, 32'd2, 1'b0, 32'd0);
    cdb_en = 1'b1; cdb_tag = 4'd2; cdb_data = 32'h8000_0000;
    tick();
    clear_inputs();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL bypass_count got=%0d exp=1", count); end
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got=%0h exp=1", res_valid); end
    checks++; if (res_taken !== 1'b1) begin errors++; $display("FAIL bypass_taken got=%0h exp=1", res_taken); end
    checks++; if (res_mispredict !== 1'b0) begin errors++; $display("FAIL bypass_mispredict got=%0h exp=0", res_mispredict); end
    checks++; if (res_next_pc !== 32'h500) begin errors++; $display("FAIL bypass_next_pc got=%0h exp=500", res_next_pc); end
    tick();
  endtask

  task automatic test_fill_backpressure();
    logic [3:0]  exp_tag [3];
    logic [31:0] exp_pc  [3];
    exp_tag = '{4'd5, 4'd6, 4'd7};
    exp_pc  = '{32'h220, 32'h230, 32'h240};
    res_ready = 1'b0;
    // Head waits on tag 5; the three younger entries are ready and taken.
    set_alloc(3'd0, 32'h200, 32'h210, 1'b1, 4'd4, 1'b1, 32'd5, 1'b0, 32'd9);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_alloc(3'd0, 32'h300, exp_pc[i], 1'b1, exp_tag[i], 1'b0, 32'd1, 1'b0, 32'd1);
      tick();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_alloc_ready got=%0h exp=0", alloc_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL fill_head_blocks got=%0h exp=0", res_valid); end
    set_alloc(3'd0, 32'h900, 32'h910, 1'b0, 4'd8, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    clear_inputs();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_fifth_ignored got=%0d exp=4", count); end
    cdb_en = 1'b1; cdb_tag = 4'd5; cdb_data = 32'd9;
    tick();
    clear_inputs();
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL fill_head_valid got=%0h exp=1", res_valid); end
    checks++; if (res_rob_tag !== 4'd4) begin errors++; $display("FAIL fill_head_tag got=%0h exp=4", res_rob_tag); end
    checks++; if (res_next_pc !== 32'h210) begin errors++; $display("FAIL fill_head_next_pc got=%0h exp=210", res_next_pc); end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fill_count_after_pop got=%0d exp=3", count); end
    tick();
    tick();
    checks++; if ({res_valid, res_rob_tag, res_taken, res_mispredict} !== {1'b1, 4'd4, 1'b1, 1'b0}) begin
      errors++; $display("FAIL hold_stable got v=%0h tag=%0h t=%0h m=%0h exp v=1 tag=4 t=1 m=0", res_valid, res_rob_tag, res_taken, res_mispredict);
    end
    checks++; if (res_next_pc !== 32'h210) begin errors++; $display("FAIL hold_next_pc got=%0h exp=210", res_next_pc); end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL hold_no_pop got=%0d exp=3", count); end
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (res_valid !== 1'b1 || res_rob_tag !== exp_tag[i]) begin
        errors++; $display("FAIL drain_order[%0d] got v=%0h tag=%0h exp v=1 tag=%0h", i, res_valid, res_rob_tag, exp_tag[i]);
      end
      checks++; if (res_next_pc !== exp_pc[i]) begin errors++; $display("FAIL drain_next_pc[%0d] got=%0h exp=%0h", i, res_next_pc, exp_pc[i]); end
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", count); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0h exp=0", res_valid); end
  endtask

  task automatic test_jr();
    set_alloc(3'd6, 32'h600, 32'h400, 1'b1, 4'd9, 1'b1, 32'd1, 1'b0, 32'd0);
    tick();
    clear_inputs();
    cdb_en = 1'b1; cdb_tag = 4'd1; cdb_data = 32'h404;
    tick();
    clear_inputs();
    tick();
    checks++; if (res_valid !== 1'b1 || res_rob_tag !== 4'd9) begin errors++; $display("FAIL jr_valid got v=%0h tag=%0h exp v=1 tag=9", res_valid, res_rob_tag); end
    checks++; if (res_taken !== 1'b1) begin errors++; $display("FAIL jr_taken got=%0h exp=1", res_taken); end
    checks++; if (res_mispredict !== 1'b1) begin errors++; $display("FAIL jr_mispredict got=%0h exp=1", res_mispredict); end
    checks++; if (res_next_pc !== 32'h404) begin errors++; $display("FAIL jr_next_pc got=%0h exp=404", res_next_pc); end
    tick();
  endtask

  // Ready-operand condition table. For cond >= 2 operand 2 is marked pending
  // (and never broadcast) to show it is ignored; cond 7 also leaves operand 1
  // pending. Expected values are worked out by hand.
  task automatic test_conditions();
    logic [2:0]  v_cond [13];
    logic [31:0] v_a    [13];
    logic [31:0] v_b    [13];
    logic        v_pred [13];
    logic [31:0] v_pc   [13];
    logic        v_t    [13];
    logic        v_m    [13];
    logic [31:0] v_next [13];
    v_cond = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd5, 3'd1, 3'd0, 3'd7, 3'd6, 3'd6};
    v_a    = '{32'h0, 32'h1, 32'h8000_0000, 32'h0, 32'h5, 32'h0, 32'h0,
               32'hFFFF_FFFF, 32'h4, 32'h4, 32'hE, 32'h2000, 32'h2000};
    v_b    = '{32'hF, 32'hF, 32'hF, 32'hF, 32'hF, 32'hF, 32'hF, 32'hF,
               32'h4, 32'h5, 32'hF, 32'hF, 32'hF};
    v_pred = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    v_pc   = '{32'h1000, 32'h1010, 32'h1020, 32'h1030, 32'h1040, 32'h1050, 32'h1060,
               32'h1070, 32'h1080, 32'h1090, 32'hFFFF_FFFC, 32'h10A0, 32'h10B0};
    v_t    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    v_m    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    v_next = '{32'h1008, 32'h2000, 32'h1028, 32'h2000, 32'h1048, 32'h1058, 32'h2000,
               32'h1078, 32'h1088, 32'h1098, 32'h0000_0004, 32'h2000, 32'h2000};
    for (int i = 0; i < 13; i++) begin
      set_alloc(v_cond[i], v_pc[i], 32'h2000, v_pred[i], 4'(i), (v_cond[i] == 3'd7),
                v_a[i], (v_cond[i] >= 3'd2), v_b[i]);
      tick();
      clear_inputs();
      tick();
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL cond[%0d]_valid got=%0h exp=1", i, res_valid); end
      checks++; if (res_taken !== v_t[i]) begin errors++; $display("FAIL cond[%0d]_taken got=%0h exp=%0h", i, res_taken, v_t[i]); end
      checks++; if (res_mispredict !== v_m[i]) begin errors++; $display("FAIL cond[%0d]_mispredict got=%0h exp=%0h", i, res_mispredict, v_m[i]); end
      checks++; if (res_next_pc !== v_next[i]) begin errors++; $display("FAIL cond[%0d]_next_pc got=%0h exp=%0h", i, res_next_pc, v_next[i]); end
      tick();
    end
  endtask

  task automatic test_flush();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_alloc(3'd0, 32'h700, 32'h780, 1'b1, 4'(i + 10), 1'b0, 32'd1, 1'b0, 32'd1);
      tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got=%0h exp=1", res_valid); end
    set_alloc(3'd0, 32'h800, 32'h880, 1'b1, 4'd14, 1'b0, 32'd1, 1'b0, 32'd1);
    flush = 1'b1;
    tick();
    clear_inputs();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_res_valid got=%0h exp=0", res_valid); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL flush_alloc_ready got=%0h exp=1", alloc_ready); end
    tick();
    checks++; if (count !== 3'd0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL flush_alloc_dropped got count=%0d v=%0h exp count=0 v=0", count, res_valid);
    end
    res_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    res_ready = 1'b0;
    set_alloc(3'd0, 32'hA00, 32'hA80, 1'b1, 4'hA, 1'b0, 32'd1, 1'b0, 32'd1);
    tick();
    set_alloc(3'd0, 32'hB00, 32'hB80, 1'b1, 4'hB, 1'b0, 32'd1, 1'b0, 32'd1);
    tick();
    clear_inputs();
    checks++; if (res_valid !== 1'b1 || count !== 3'd1) begin
      errors++; $display("FAIL areset_pre got v=%0h count=%0d exp v=1 count=1", res_valid, count);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL areset_res_valid got=%0h exp=0", res_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", count); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL areset_alloc_ready got=%0h exp=1", alloc_ready); end
    checks++; if ({res_rob_tag, res_taken, res_next_pc} !== '0) begin
      errors++; $display("FAIL areset_fields got tag=%0h t=%0h pc=%0h exp all 0", res_rob_tag, res_taken, res_next_pc);
    end
    #1;
    rst = 1'b1;
    res_ready = 1'b1;
    tick();
    checks++; if (res_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL areset_nothing_survives got v=%0h count=%0d exp v=0 count=0", res_valid, count);
    end
    set_alloc(3'd0, 32'hC00, 32'hC80, 1'b0, 4'hC, 1'b0, 32'd1, 1'b0, 32'd2);
    tick();
    clear_inputs();
    tick();
    checks++; if (res_valid !== 1'b1 || res_rob_tag !== 4'hC) begin
      errors++; $display("FAIL areset_resume got v=%0h tag=%0h exp v=1 tag=c", res_valid, res_rob_tag);
    end
    checks++; if (res_next_pc !== 32'hC08) begin errors++; $display("FAIL areset_resume_next_pc got=%0h exp=c08", res_next_pc); end
    tick();
  endtask

  initial begin
    test_reset();
    test_ready_beq();
    test_pending_bne();
    test_bypass();
    test_fill_backpressure();
    test_jr();
    test_conditions();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Successor to the ID-stage branch generator for the out-of-order core.
- ID emits undetermined branches and jump-registers, i.e. operands still pending as ROB references. This block buffers them in a parametrised in-order queue.
- It snoops the CDB for pending operands, evaluates the condition when the head entry is ready, and emits one resolution per cycle, in program order, with a mispredict flag and the corrected next PC for the front-end redirect.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2.
- TAG_WIDTH, 4, ROB tag width.
- ADDR_WIDTH, 32, PC / target width.
- DATA_WIDTH, 32, operand width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; empties the queue.
- alloc_en  in  1  allocate one entry this cycle.
- alloc_ready  out  1  high when the queue is not full.
- alloc_cond  in  3  condition code: 0 EQ, 1 NE, 2 GTZ, 3 LEZ, 4 LTZ, 5 GEZ, 6 JR, 7 reserved.
- alloc_pc  in  ADDR_WIDTH  branch PC.
- alloc_target  in  ADDR_WIDTH  branch target; for JR, the predicted target.
- alloc_pred_taken  in  1  front-end prediction.
- alloc_rob_tag  in  TAG_WIDTH  ROB tag of the branch.
- alloc_is_ref_1 / alloc_is_ref_2  in  1  operand pending; its tag is in data[TAG_WIDTH-1:0].
- alloc_data_1 / alloc_data_2  in  DATA_WIDTH  operand value, or tag when pending.
- cdb_en  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_WIDTH  broadcast tag.
- cdb_data  in  DATA_WIDTH  broadcast value.
- res_valid  out  1  resolution valid.
- res_ready  in  1  consumer accepts the resolution.
- res_rob_tag  out  TAG_WIDTH  ROB tag of the resolved branch.
- res_taken  out  1  actual direction.
- res_mispredict  out  1  redirect required.
- res_next_pc  out  ADDR_WIDTH  correct next fetch PC.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (rst low, asynchronous):
  - head = tail = 0, all entries invalid, output register empty.
  - res_* = 0, count = 0, alloc_ready = 1.
- Storage:
  - Circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping DEPTH-1 → 0.
  - full/empty are derived from count.
- Allocation:
  - alloc_en && alloc_ready writes the entry at tail on the edge; tail++, count++.
  - alloc_ready = (count != DEPTH) and depends on registered state only. A pop in the same cycle does not free a slot for a full-queue allocate.
  - alloc_en while full is ignored; no state changes.
- Operands:
  - For cond 2–6, operand 2 is ignored and treated as ready.
  - Reserved cond 7 resolves as not-taken with no operands required.
- CDB snoop:
  - Each edge, every valid entry with a pending operand whose tag == cdb_tag (cdb_en=1) captures cdb_data and clears its pending flag. All entries update in parallel.
  - Same-cycle alloc and matching CDB: the new entry stores cdb_data as ready (bypass).
- Head resolution:
  - The head is resolvable when valid and all required operands are ready.
  - If resolvable and (res_valid==0 || res_ready), the result loads into the output register on the edge; head++, count--.
  - Allocate and pop in the same cycle leave count unchanged.
- Output register hold: res_valid && !res_ready holds all res_* stable, and the head is not popped.
- Conditions:
  - EQ: a==b. NE: a!=b.
  - GTZ: !a[MSB] && a!=0. LEZ: a[MSB] || a==0.
  - LTZ: a[MSB]. GEZ: !a[MSB].
- Result for conditional branches:
  - res_mispredict = taken != pred_taken.
  - res_next_pc = taken ? target : pc+8 (delay slot), computed modulo 2^ADDR_WIDTH.
- Result for JR:
  - res_taken = 1.
  - res_mispredict = !pred_taken || (op1 != target).
  - res_next_pc = op1.
- Latency: an entry allocated with ready operands at edge E0 gives res_valid=1 after E1 (1 cycle).
- Ordering: strictly in order; a ready younger entry waits behind a pending head.
- Flush:
  - On the edge it invalidates all entries and the output register; head = tail = 0, count = 0.
  - It takes priority over alloc, CDB capture and pop in the same cycle.
- Mid-operation reset behaves identically to power-up reset; no entry survives.

Test Plan:
- Ready BEQ: alloc cond=0, data 5/5, pc=0x100, target=0x200, pred=0 → next cycle res_valid=1, taken=1, mispredict=1, next_pc=0x200.
- Pending BNE: op1 ref tag 3; then CDB tag=3 data=7, op2=7 → resolves the cycle after the CDB edge with taken=0. With pred=0: mispredict=0, next_pc=pc+8.
- Bypass: alloc BLTZ, op1 ref tag 2, with cdb_en tag=2 data=0x80000000 in the same cycle → res taken=1 one cycle later, with no further CDB.
- Fill and back-pressure with DEPTH=4:
  - Four allocs with head pending → alloc_ready=0, count=4; a fifth alloc is ignored.
  - Release the head via CDB and hold res_ready=0 → res_* stay stable.
  - Raise res_ready → entries drain in allocation order; pointers wrap.
- JR: pred_taken=1, target=0x400, op1 resolves to 0x404 → taken=1, mispredict=1, next_pc=0x404.
- Flush and reset:
  - Flush asserted with 3 entries and res_valid=1, plus a simultaneous alloc → next edge count=0, res_valid=0, alloc dropped.
  - Async rst pulse mid-stream → outputs 0 immediately, without waiting for a clock edge.
